// File: rtl/vx_warp_ibuffer_pkg.sv
// vx_warp_ibuffer_pkg: GPU-wide constants and warp-id helpers shared by the issue-slice instruction buffer
package vx_warp_ibuffer_pkg;

    localparam int NUM_WARPS       = 8;
    localparam int ISSUE_WIDTH     = 2;
    localparam int PER_ISSUE_WARPS = NUM_WARPS / ISSUE_WIDTH;
    localparam int NW_WIDTH        = $clog2(NUM_WARPS);
    localparam int ISSUE_ISW_W     = $clog2(ISSUE_WIDTH);
    localparam int ISSUE_WIS_W     = $clog2(PER_ISSUE_WARPS);

    localparam int UUID_WIDTH      = 16;
    localparam int NUM_THREADS     = 4;
    localparam int PC_BITS         = 32;
    localparam int EX_BITS         = 3;
    localparam int INST_OP_BITS    = 4;
    localparam int INST_ARGS_BITS  = 16;
    localparam int NUM_SRC_OPDS    = 3;
    localparam int NUM_REGS_BITS   = 6;
    localparam int PERF_CTR_BITS   = 44;

    // uuid, tmask, PC, ex_type, op_type, op_args, wb, used_rs, rd, rs1, rs2, rs3 (uuid in the MSBs)
    localparam int IBUF_DATAW = UUID_WIDTH + NUM_THREADS + PC_BITS + EX_BITS + INST_OP_BITS
                              + INST_ARGS_BITS + 1 + NUM_SRC_OPDS + 4 * NUM_REGS_BITS;

    // decode payload carries the warp id above the buffered fields
    localparam int DECODE_DATAW = NW_WIDTH + IBUF_DATAW;

    function automatic logic [ISSUE_WIS_W-1:0] wid_to_wis(input logic [NW_WIDTH-1:0] wid);
        return ISSUE_WIS_W'(wid >> ISSUE_ISW_W);
    endfunction

    function automatic logic [ISSUE_ISW_W-1:0] wid_to_isw(input logic [NW_WIDTH-1:0] wid);
        return wid[ISSUE_ISW_W-1:0];
    endfunction

endpackage

// File: rtl/vx_warp_ibuffer_fifo.sv
// vx_warp_ibuffer_fifo: single-warp register FIFO with registered occupancy and no bypass
module vx_warp_ibuffer_fifo #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = mem[rd_ptr];

    // pointers wrap naturally since DEPTH is a power of two; push+pop leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage is left unreset; only occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

`ifndef SYNTHESIS
    // occupancy must stay within 0..DEPTH
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= (AW+1)'(DEPTH)) else $error("fifo count overflow");
            assert (!(push && full)) else $error("fifo push while full");
            assert (!(pop && empty)) else $error("fifo pop while empty");
        end
    end
`endif

endmodule

// File: rtl/vx_warp_ibuffer.sv
// vx_warp_ibuffer: steers decoded instructions into per-warp FIFOs feeding the scoreboard lanes
module vx_warp_ibuffer import vx_warp_ibuffer_pkg::*; #(
    parameter string INSTANCE_ID = "",
    parameter int    ISSUE_ID    = 0,
    parameter int    DEPTH       = 4,
    parameter bit    PERF_ENABLE = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  decode_if_valid,
    output logic                                  decode_if_ready,
    input  logic [DECODE_DATAW-1:0]               decode_if_data,
    output logic [PER_ISSUE_WARPS-1:0]            ibuffer_if_valid,
    input  logic [PER_ISSUE_WARPS-1:0]            ibuffer_if_ready,
    output logic [PER_ISSUE_WARPS*IBUF_DATAW-1:0] ibuffer_if_data,
    output logic [PER_ISSUE_WARPS-1:0]            ibuf_pop,
    output logic [PERF_CTR_BITS-1:0]              perf_full_stalls
);

    logic [NW_WIDTH-1:0]        wid;
    logic [ISSUE_WIS_W-1:0]     wis;
    logic [PER_ISSUE_WARPS-1:0] push;
    logic [PER_ISSUE_WARPS-1:0] pop;
    logic [PER_ISSUE_WARPS-1:0] full;
    logic [PER_ISSUE_WARPS-1:0] empty;

    assign wid = decode_if_data[DECODE_DATAW-1 -: NW_WIDTH];
    assign wis = wid_to_wis(wid);

    // ready comes only from registered occupancy, so downstream ready never reaches decode combinationally
    assign decode_if_ready = ~full[wis];
    assign ibuf_pop        = pop;

    for (genvar w = 0; w < PER_ISSUE_WARPS; w++) begin : g_warp
        assign push[w]             = decode_if_valid && decode_if_ready && (wis == ISSUE_WIS_W'(w));
        assign pop[w]              = ibuffer_if_valid[w] && ibuffer_if_ready[w];
        assign ibuffer_if_valid[w] = ~empty[w];

        vx_warp_ibuffer_fifo #(
            .DATAW (IBUF_DATAW),
            .DEPTH (DEPTH)
        ) fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[w]),
            .pop      (pop[w]),
            .data_in  (decode_if_data[IBUF_DATAW-1:0]),
            .data_out (ibuffer_if_data[w*IBUF_DATAW +: IBUF_DATAW]),
            .full     (full[w]),
            .empty    (empty[w])
        );
    end

    // count cycles where decode holds an instruction its warp FIFO cannot take
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_full_stalls <= '0;
        else if (PERF_ENABLE && decode_if_valid && !decode_if_ready)
            perf_full_stalls <= perf_full_stalls + 1'b1;
    end

`ifndef SYNTHESIS
    // only warps owned by this issue slice may arrive here
    always_ff @(posedge clk) begin
        if (!reset && decode_if_valid)
            assert (wid_to_isw(wid) == ISSUE_ISW_W'(ISSUE_ID))
                else $error("%s: wid %0d not in issue slice %0d", INSTANCE_ID, wid, ISSUE_ID);
    end
`endif

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// tb_vx_warp_ibuffer: randomized and directed scoreboard bench for the per-warp instruction buffer
module tb_vx_warp_ibuffer;
    import vx_warp_ibuffer_pkg::*;

    localparam int DEPTH    = 4;
    localparam int PW       = PER_ISSUE_WARPS;
    localparam int ISSUE_ID = 0;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     dv = 1'b0;
    logic                     dr;
    logic [DECODE_DATAW-1:0]  dd = '0;
    logic [PW-1:0]            iv;
    logic [PW-1:0]            ir = '0;
    logic [PW*IBUF_DATAW-1:0] idata;
    logic [PW-1:0]            ipop;
    logic [PERF_CTR_BITS-1:0] perf;

    always #5 clk = ~clk;

    vx_warp_ibuffer #(
        .INSTANCE_ID ("ibuf0"),
        .ISSUE_ID    (ISSUE_ID),
        .DEPTH       (DEPTH),
        .PERF_ENABLE (1'b1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .decode_if_valid  (dv),
        .decode_if_ready  (dr),
        .decode_if_data   (dd),
        .ibuffer_if_valid (iv),
        .ibuffer_if_ready (ir),
        .ibuffer_if_data  (idata),
        .ibuf_pop         (ipop),
        .perf_full_stalls (perf)
    );

    logic [IBUF_DATAW-1:0] q [PW][$];
    int    vectors = 0;
    int    miscompares = 0;
    longint stalls = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wis_of(input logic [DECODE_DATAW-1:0] d);
        return int'(d[DECODE_DATAW-1 -: NW_WIDTH]) / ISSUE_WIDTH;
    endfunction

    function automatic logic [DECODE_DATAW-1:0] mk(input int wis, input int uuid);
        logic [IBUF_DATAW-UUID_WIDTH-1:0] rest;
        logic [NW_WIDTH-1:0] wid;
        rest = (IBUF_DATAW-UUID_WIDTH)'({$urandom, $urandom, $urandom});
        wid  = NW_WIDTH'(wis * ISSUE_WIDTH + ISSUE_ID);
        return {wid, UUID_WIDTH'(uuid), rest};
    endfunction

    function automatic logic [UUID_WIDTH-1:0] out_uuid(input int w);
        logic [IBUF_DATAW-1:0] e;
        e = idata[w*IBUF_DATAW +: IBUF_DATAW];
        return e[IBUF_DATAW-1 -: UUID_WIDTH];
    endfunction

    // one cycle of stimulus; the accepted entry joins the scoreboard after this cycle's monitor pass
    task automatic step(input logic v, input logic [DECODE_DATAW-1:0] d, input logic [PW-1:0] rdy, output logic acc);
        int w;
        @(posedge clk);
        #1;
        dv = v;
        dd = d;
        ir = rdy;
        w = wis_of(d);
        acc = v && !reset && (q[w].size() < DEPTH);
        #5;
        if (acc) q[w].push_back(d[IBUF_DATAW-1:0]);
    endtask

    // monitor: compares every lane and the decode side against the scoreboard on the falling edge
    initial begin
        int  w;
        bit  er;
        bit  ev;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_decode_ready", dr, 1);
                check("rst_valid", iv, 0);
                check("rst_ibuf_pop", ipop, 0);
                check("rst_perf", perf, 0);
                for (int k = 0; k < PW; k++) q[k].delete();
                stalls = 0;
            end else begin
                w  = wis_of(dd);
                er = q[w].size() < DEPTH;
                check("decode_ready", dr, er);
                check("perf_full_stalls", perf, stalls);
                for (int k = 0; k < PW; k++) begin
                    ev = q[k].size() != 0;
                    check("ibuf_valid", iv[k], ev);
                    check("ibuf_pop", ipop[k], ev && ir[k]);
                    if (ev) begin
                        check("ibuf_data", idata[k*IBUF_DATAW +: IBUF_DATAW], q[k][0]);
                        if (ir[k]) void'(q[k].pop_front());
                    end
                end
                if (dv && !er) stalls++;
            end
        end
    end

    initial begin
        logic acc;
        logic [DECODE_DATAW-1:0] d5;
        int i;
        int pops;
        int guard;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // fill warp 0 with lane blocked, then stall, then drain in order
        for (int k = 0; k < 4; k++) begin
            step(1'b1, mk(0, k), '0, acc);
            check("fill_ready", dr, 1);
        end
        d5 = mk(0, 4);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, d5, '0, acc);
            check("stall_ready", dr, 0);
        end
        step(1'b0, d5, '0, acc);
        check("stall_count", perf, 3);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, d5, PW'(1), acc);
            check("drain_pop", ipop[0], 1);
            check("drain_uuid", out_uuid(0), k);
        end
        step(1'b0, d5, '0, acc);
        check("drain_empty", iv[0], 0);

        // warp 1 full and blocked does not block warp 2
        for (int k = 0; k < 4; k++) step(1'b1, mk(1, 10 + k), '0, acc);
        step(1'b1, mk(2, 20), '0, acc);
        check("indep_ready", dr, 1);
        check("indep_no_bypass", iv[2], 0);
        step(1'b0, mk(1, 0), '0, acc);
        check("indep_valid", iv[2], 1);
        check("indep_w1_held", iv[1], 1);
        repeat (6) step(1'b0, mk(0, 0), '1, acc);
        check("indep_drained", iv, 0);

        // push and pop at full: registered full blocks the first attempt only
        for (int k = 0; k < 4; k++) step(1'b1, mk(0, 30 + k), '0, acc);
        step(1'b1, mk(0, 40), PW'(1), acc);
        check("full_pp_ready", dr, 0);
        check("full_pp_pop", ipop[0], 1);
        step(1'b1, mk(0, 41), PW'(1), acc);
        check("full_pp_next", dr, 1);
        step(1'b1, mk(0, 42), PW'(1), acc);
        check("full_pp_steady", dr, 1);
        repeat (6) step(1'b0, mk(0, 0), '1, acc);

        // wrap-around stream through warp 3 with random ready
        i = 0;
        pops = 0;
        guard = 0;
        while ((i < 20 || q[3].size() != 0) && guard < 400) begin
            step(i < 20, mk(3, 100 + i), PW'(($urandom & 1) << 3), acc);
            if (acc) i++;
            pops += int'(ipop[3]);
            guard++;
        end
        check("wrap_pushes", i, 20);
        check("wrap_pops", pops, 20);

        // reset with entries in flight
        for (int k = 0; k < 2; k++) step(1'b1, mk(0, 50 + k), '0, acc);
        for (int k = 0; k < 3; k++) step(1'b1, mk(1, 60 + k), '0, acc);
        step(1'b0, mk(0, 0), '0, acc);
        reset = 1'b1;
        #1;
        check("midrst_valid", iv, 0);
        check("midrst_ready", dr, 1);
        step(1'b0, mk(0, 0), '0, acc);
        reset = 1'b0;
        step(1'b1, mk(0, 200), PW'(1), acc);
        check("postrst_ready", dr, 1);
        check("postrst_no_bypass", iv[0], 0);
        step(1'b0, mk(0, 0), PW'(1), acc);
        check("postrst_valid", iv[0], 1);
        check("postrst_uuid", out_uuid(0), 200);
        step(1'b0, mk(0, 0), PW'(1), acc);
        check("postrst_empty", iv, 0);

        // single-entry pass-through on an empty warp
        step(1'b1, mk(2, 300), '1, acc);
        check("pass_n_valid", iv[2], 0);
        check("pass_n_pop", ipop[2], 0);
        step(1'b0, mk(2, 0), '1, acc);
        check("pass_n1_valid", iv[2], 1);
        check("pass_n1_pop", ipop[2], 1);
        step(1'b0, mk(2, 0), '1, acc);
        check("pass_n2_valid", iv[2], 0);

        // random traffic across all warps
        for (int k = 0; k < 300; k++)
            step(($urandom % 4) != 0, mk(int'($urandom % PW), 1000 + k), PW'($urandom), acc);
        repeat (2 * DEPTH + 2) step(1'b0, mk(0, 0), '1, acc);
        check("final_empty", iv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
